// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary helpers
// used by both the read and write controllers.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_MAX_PTR_W  = 32;

    typedef logic [FIFO_MAX_PTR_W-1:0] fifo_ptr_t;

    // Helpers take zero-extended pointers; bits at and above width are cleared.
    function automatic fifo_ptr_t ptr_mask(input int width);
        fifo_ptr_t mask;
        if (width >= FIFO_MAX_PTR_W) begin
            mask = '1;
        end else begin
            mask = (fifo_ptr_t'(1) << width) - fifo_ptr_t'(1);
        end
        return mask;
    endfunction

    function automatic fifo_ptr_t bin2gray(input fifo_ptr_t bin, input int width);
        fifo_ptr_t b;
        b = bin & ptr_mask(width);
        return b ^ (b >> 1);
    endfunction

    function automatic fifo_ptr_t gray2bin(input fifo_ptr_t gray, input int width);
        fifo_ptr_t g;
        fifo_ptr_t b;
        g = gray & ptr_mask(width);
        b = '0;
        b[FIFO_MAX_PTR_W-1] = g[FIFO_MAX_PTR_W-1];
        for (int i = FIFO_MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the read-side level logic and the write side.
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_ADDR_WIDTH + 1
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller (rclk domain) with FWFT output register.
// Define FIFO_RD_LEVEL_EN to build the rlevel/raempty occupancy logic.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata_mem,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]      r_bin;
    logic [PTR_W-1:0]      r_gray;
    logic                  r_empty;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_rinc;
    logic [PTR_W-1:0]      w_binnext;
    logic [PTR_W-1:0]      w_graynext;

    // Pop whenever memory has a word and the output slot is free or draining.
    assign w_rinc     = !r_empty && (!r_valid || m_ready);
    assign w_binnext  = r_bin + PTR_W'(w_rinc);
    assign w_graynext = w_binnext ^ (w_binnext >> 1);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_empty <= 1'b1;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_bin   <= w_binnext;
            r_gray  <= w_graynext;
            // Gray compare: the synchronized pointer is only trusted in Gray form.
            r_empty <= (w_graynext == rq2_wptr);
            if (w_rinc) begin
                r_data  <= rdata_mem;
                r_valid <= 1'b1;
            end else if (r_valid && m_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rptr    = r_gray;
    assign raddr   = r_bin[ADDR_WIDTH-1:0];
    assign rempty  = r_empty;
    assign m_valid = r_valid;
    assign m_data  = r_data;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [PTR_W-1:0] THRESH = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] w_wbin;
    logic [PTR_W-1:0] w_level;
    logic [PTR_W-1:0] r_level;
    logic             r_aempty;

    fifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_wptr_g2b (
        .i_gray (rq2_wptr),
        .o_bin  (w_wbin)
    );

    // Modular difference; the pointer MSB makes a full memory read as 2^ADDR_WIDTH.
    assign w_level = w_wbin - r_bin;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_level  <= '0;
            r_aempty <= 1'b1;
        end else begin
            r_level  <= w_level;
            r_aempty <= (w_level <= THRESH);
        end
    end

    assign rlevel  = r_level;
    assign raempty = r_aempty;
`else
    assign rlevel  = '0;
    assign raempty = r_empty;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: vector table, corner sequences and a
// word-queue reference model driven with random write steps and backpressure.
module tb_fifo_rd_ctrl;

    localparam int AW     = 4;
    localparam int DW     = 32;
    localparam int PW     = AW + 1;
    localparam int DEPTH  = 1 << AW;
    localparam int THRESH = 2;

    logic          rclk     = 1'b0;
    logic          rrst_n   = 1'b0;
    logic [PW-1:0] rq2_wptr = '0;
    logic [PW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata_mem;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready  = 1'b0;
    logic          rempty;
    logic          raempty;
    logic [PW-1:0] rlevel;

    logic [DW-1:0] mem [DEPTH];
    assign rdata_mem = mem[raddr];

    fifo_rd_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .AEMPTY_THRESH (THRESH)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rq2_wptr  (rq2_wptr),
        .rptr      (rptr),
        .raddr     (raddr),
        .rdata_mem (rdata_mem),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .rempty    (rempty),
        .raempty   (raempty),
        .rlevel    (rlevel)
    );

    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words written (wr) and popped (rd) as plain counts.
    int            wr;
    int            rd;
    int            serial;
    int            n_xfer;
    bit            e_empty;
    bit            e_valid;
    bit            e_aempty;
    logic [DW-1:0] e_data;
    int            e_level;
    logic [DW-1:0] q[$];

    typedef struct {
        int            w;
        bit            rdy;
        bit            x_empty;
        bit            x_valid;
        logic [DW-1:0] x_data;
        logic [PW-1:0] x_rptr;
    } vec_t;

    vec_t vt [8];

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rd       = 0;
        wr       = 0;
        e_empty  = 1'b1;
        e_valid  = 1'b0;
        e_aempty = 1'b1;
        e_data   = '0;
        e_level  = 0;
        q.delete();
    endtask

    task automatic push_word();
        logic [DW-1:0] d;
        serial++;
        d = 32'hA5A5_0000 + 32'(serial);
        mem[wr % DEPTH] = d;
        q.push_back(d);
        wr++;
        rq2_wptr = to_gray(wr);
    endtask

    task automatic tick();
        bit            pop;
        bit            n_empty;
        bit            n_valid;
        bit            n_aempty;
        logic [DW-1:0] n_data;
        int            n_level;
        int            rd_new;
        if (!rrst_n) begin
            @(posedge rclk);
            #1;
            return;
        end
        pop     = !e_empty && (!e_valid || m_ready);
        n_valid = e_valid;
        n_data  = e_data;
        if (e_valid && m_ready) begin
            n_xfer++;
            $display("xfer %0d data=%h", n_xfer, e_data);
        end
        if (pop) begin
            n_data  = q.pop_front();
            n_valid = 1'b1;
        end else if (e_valid && m_ready) begin
            n_valid = 1'b0;
        end
        rd_new  = rd + (pop ? 1 : 0);
        n_empty = (rd_new == wr);
`ifdef FIFO_RD_LEVEL_EN
        n_level  = wr - rd;
        n_aempty = (n_level <= THRESH);
`else
        n_level  = 0;
        n_aempty = n_empty;
`endif
        @(posedge rclk);
        rd       = rd_new;
        e_empty  = n_empty;
        e_valid  = n_valid;
        e_data   = n_data;
        e_level  = n_level;
        e_aempty = n_aempty;
        #1;
    endtask

    task automatic check_model();
        chk("rempty",  32'(rempty),  32'(e_empty));
        chk("m_valid", 32'(m_valid), 32'(e_valid));
        chk("m_data",  m_data,       e_data);
        chk("rptr",    32'(rptr),    32'(to_gray(rd)));
        chk("raddr",   32'(raddr),   32'(rd % DEPTH));
        chk("rlevel",  32'(rlevel),  32'(e_level));
        chk("raempty", 32'(raempty), 32'(e_aempty));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rempty"},  32'(rempty),  32'd1);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"},  m_data,       32'd0);
        chk({tag, "_rptr"},    32'(rptr),    32'd0);
        chk({tag, "_raddr"},   32'(raddr),   32'd0);
        chk({tag, "_rlevel"},  32'(rlevel),  32'd0);
        chk({tag, "_raempty"}, 32'(raempty), 32'd1);
    endtask

    initial begin
        int nvalid;
        int peak;
        int pushed;
        int guard;
        int base;
        int k;

        vt[0] = '{w: 0, rdy: 1'b0, x_empty: 1'b1, x_valid: 1'b0, x_data: 32'h0,         x_rptr: 5'b00000};
        vt[1] = '{w: 1, rdy: 1'b0, x_empty: 1'b0, x_valid: 1'b0, x_data: 32'h0,         x_rptr: 5'b00000};
        vt[2] = '{w: 1, rdy: 1'b0, x_empty: 1'b1, x_valid: 1'b1, x_data: 32'hA5A5_0001, x_rptr: 5'b00001};
        vt[3] = '{w: 1, rdy: 1'b0, x_empty: 1'b1, x_valid: 1'b1, x_data: 32'hA5A5_0001, x_rptr: 5'b00001};
        vt[4] = '{w: 1, rdy: 1'b1, x_empty: 1'b1, x_valid: 1'b0, x_data: 32'hA5A5_0001, x_rptr: 5'b00001};
        vt[5] = '{w: 2, rdy: 1'b0, x_empty: 1'b0, x_valid: 1'b0, x_data: 32'hA5A5_0001, x_rptr: 5'b00001};
        vt[6] = '{w: 2, rdy: 1'b1, x_empty: 1'b1, x_valid: 1'b1, x_data: 32'hA5A5_0002, x_rptr: 5'b00011};
        vt[7] = '{w: 2, rdy: 1'b1, x_empty: 1'b1, x_valid: 1'b0, x_data: 32'hA5A5_0002, x_rptr: 5'b00011};

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        serial = 0;
        n_xfer = 0;
        model_reset();

        // Reset held with a non-zero write pointer.
        rq2_wptr = 5'b00011;
        tick();
        tick();
        chk("reset_rempty",  32'(rempty),  32'd1);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_rptr",    32'(rptr),    32'd0);
        chk("reset_rlevel",  32'(rlevel),  32'd0);
        rq2_wptr = '0;
        tick();
        rrst_n = 1'b1;

        // Single-word latency and handshake table.
        for (int i = 0; i < 8; i++) begin
            while (wr < vt[i].w) push_word();
            m_ready = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_rempty", i),  32'(rempty),  32'(vt[i].x_empty));
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vt[i].x_valid));
            chk($sformatf("vec%0d_m_data", i),  m_data,       vt[i].x_data);
            chk($sformatf("vec%0d_rptr", i),    32'(rptr),    32'(vt[i].x_rptr));
            check_model();
        end

        // Full-depth burst with the consumer always ready.
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_word();
        nvalid = 0;
        peak   = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            check_model();
            if (m_valid) nvalid++;
            if (int'(rlevel) > peak) peak = int'(rlevel);
        end
        chk("burst_valid_cycles", 32'(nvalid), 32'd16);
`ifdef FIFO_RD_LEVEL_EN
        chk("burst_peak_level", 32'(peak), 32'd16);
`endif

        // Backpressure with four words available.
        m_ready = 1'b0;
        base = rd;
        for (int i = 0; i < 4; i++) push_word();
        for (int i = 0; i < 12; i++) begin
            tick();
            check_model();
        end
        chk("bp_rptr", 32'(rptr), 32'(to_gray(base + 1)));
        chk("bp_data", m_data, 32'hA5A5_0000 + 32'(serial - 3));
`ifdef FIFO_RD_LEVEL_EN
        chk("bp_level", 32'(rlevel), 32'd3);
`endif
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_model();
        end

        // Wrap: 40 words in write steps of up to 7, random backpressure.
        pushed = 0;
        guard  = 0;
        while (pushed < 40 && guard < 2000) begin
            k = (40 - pushed < 7) ? 40 - pushed : 7;
            if (wr - rd + k <= DEPTH) begin
                for (int j = 0; j < k; j++) push_word();
                pushed += k;
            end
            m_ready = 1'($urandom_range(0, 1));
            tick();
            check_model();
            guard++;
        end
        chk("wrap_words_pushed", 32'(pushed), 32'd40);
        m_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            check_model();
        end
        chk("wrap_drain_rptr", 32'(rptr), 32'(to_gray(wr)));

        // Reset in the middle of a 10-word burst.
        for (int i = 0; i < 10; i++) push_word();
        base  = n_xfer;
        guard = 0;
        while (n_xfer - base < 5 && guard < 40) begin
            tick();
            check_model();
            guard++;
        end
        chk("midrst_xfers_before", 32'(n_xfer - base), 32'd5);
        #2;
        rrst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        rq2_wptr = '0;
        tick();
        tick();
        rrst_n = 1'b1;

        // Random traffic from pointer 0.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(1, 4));
                for (int j = 0; j < k; j++) begin
                    if (wr - rd < DEPTH) push_word();
                end
            end
            m_ready = 1'($urandom_range(0, 3) != 0);
            tick();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
